// File: rtl/ip_tx_arbiter.sv
// Round-robin arbiter sharing the ip_tx request/payload path between ICMP (port 0) and UDP (port 1).
// Latency: a request sampled in IDLE raises ip_tx_req on the next edge; the payload mux is combinational during XFER.
// Backpressure: requests wait in IDLE while a frame is active; a watchdog aborts frames that ip_tx never ends.
module ip_tx_arbiter #(
    parameter logic [7:0]  ICMP_TYPE = 8'd1,
    parameter logic [7:0]  UDP_TYPE  = 8'd17,
    parameter logic [19:0] WDOG_MAX  = 20'd200000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        icmp_req,
    input  logic [15:0] icmp_length,
    input  logic        icmp_tx_ready,
    input  logic [7:0]  icmp_data,
    output logic        icmp_data_req,
    output logic        icmp_ack,
    output logic        icmp_done,
    output logic        icmp_err,
    input  logic        udp_req,
    input  logic [15:0] udp_length,
    input  logic        udp_tx_ready,
    input  logic [7:0]  udp_data,
    output logic        udp_data_req,
    output logic        udp_ack,
    output logic        udp_done,
    output logic        udp_err,
    output logic        ip_tx_req,
    input  logic        ip_tx_ack,
    output logic [7:0]  ip_send_type,
    output logic [15:0] ip_send_data_length,
    output logic [7:0]  upper_layer_data,
    output logic        upper_tx_ready,
    input  logic        upper_data_req,
    input  logic        ip_tx_end,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t      state;
    logic        grant;
    logic        rr_ptr;
    logic [19:0] wdog;
    logic        pick;
    logic        wdog_expired;
    logic        abort;
    logic        xfer;

    // With both ports requesting, rr_ptr breaks the tie; otherwise the lone requester wins.
    assign pick         = (icmp_req && udp_req) ? rr_ptr : udp_req;
    assign wdog_expired = (wdog >= WDOG_MAX - 20'd1);
    // ack and end take precedence over a watchdog expiry in the same cycle
    assign abort        = wdog_expired &&
                          ((state == REQ && !ip_tx_ack) || (state == XFER && !ip_tx_end));
    assign xfer         = (state == XFER);

    assign upper_layer_data = xfer ? (grant ? udp_data : icmp_data) : 8'd0;
    assign upper_tx_ready   = xfer && (grant ? udp_tx_ready : icmp_tx_ready);
    assign icmp_data_req    = xfer && !grant && upper_data_req;
    assign udp_data_req     = xfer && grant && upper_data_req;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state               <= IDLE;
            grant               <= 1'b0;
            rr_ptr              <= 1'b0;
            wdog                <= 20'd0;
            ip_tx_req           <= 1'b0;
            ip_send_type        <= 8'd0;
            ip_send_data_length <= 16'd0;
            busy                <= 1'b0;
            icmp_ack            <= 1'b0;
            icmp_done           <= 1'b0;
            icmp_err            <= 1'b0;
            udp_ack             <= 1'b0;
            udp_done            <= 1'b0;
            udp_err             <= 1'b0;
        end else begin
            icmp_ack  <= 1'b0;
            icmp_done <= 1'b0;
            icmp_err  <= 1'b0;
            udp_ack   <= 1'b0;
            udp_done  <= 1'b0;
            udp_err   <= 1'b0;
            if (abort) begin
                icmp_err            <= !grant;
                udp_err             <= grant;
                rr_ptr              <= !grant;
                ip_tx_req           <= 1'b0;
                busy                <= 1'b0;
                ip_send_type        <= 8'd0;
                ip_send_data_length <= 16'd0;
                wdog                <= 20'd0;
                state               <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        wdog <= 20'd0;
                        if (icmp_req || udp_req) begin
                            grant               <= pick;
                            ip_send_type        <= pick ? UDP_TYPE : ICMP_TYPE;
                            ip_send_data_length <= pick ? udp_length : icmp_length;
                            ip_tx_req           <= 1'b1;
                            busy                <= 1'b1;
                            state               <= REQ;
                        end
                    end
                    REQ: begin
                        wdog <= wdog + 20'd1;
                        if (ip_tx_ack) begin
                            ip_tx_req <= 1'b0;
                            icmp_ack  <= !grant;
                            udp_ack   <= grant;
                            state     <= XFER;
                        end
                    end
                    XFER: begin
                        if (ip_tx_end) begin
                            icmp_done <= !grant;
                            udp_done  <= grant;
                            rr_ptr    <= !grant;
                            busy      <= 1'b0;
                            wdog      <= 20'd0;
                            state     <= DONE;
                        end else begin
                            wdog <= wdog + 20'd1;
                        end
                    end
                    DONE: begin
                        ip_send_type        <= 8'd0;
                        ip_send_data_length <= 16'd0;
                        wdog                <= 20'd0;
                        state               <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/ip_tx_arbiter.md
Name: ip_tx_arbiter

Overview:
- Shares the single IP transmit datapath (`ip_tx`) between two upper-layer requesters: ICMP (port 0) and UDP (port 1).
- Sequences each frame end to end: round-robin grant, the IP request/ack handshake, and muxing of payload data and ready/request strobes to the granted source.
- Detects end-of-frame or abort, then releases the grant.
- Sits between the ICMP/UDP transmit engines and `ip_tx`; it is the only driver of `ip_tx`'s request-side inputs.

Parameters:
- ICMP_TYPE, 8'd1, protocol number driven on ip_send_type when ICMP is granted.
- UDP_TYPE, 8'd17, protocol number driven on ip_send_type when UDP is granted.
- WDOG_MAX, 20'd200000, watchdog limit in cycles for REQ+XFER. Must exceed the `ip_tx` internal 65535-cycle wait timeout.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- icmp_req  in  1  ICMP frame request, level
- icmp_length  in  16  ICMP IP total length
- icmp_tx_ready  in  1  ICMP payload ready
- icmp_data  in  8  ICMP payload byte
- icmp_data_req  out  1  payload request routed to ICMP
- icmp_ack  out  1  1-cycle pulse: ICMP frame accepted by `ip_tx`
- icmp_done  out  1  1-cycle pulse: ICMP frame finished
- icmp_err  out  1  1-cycle pulse: ICMP frame aborted by watchdog
- udp_req, udp_length, udp_tx_ready, udp_data, udp_data_req, udp_ack, udp_done, udp_err: same directions, widths and meanings as the icmp_* ports, for UDP
- ip_tx_req  out  1  request to `ip_tx`
- ip_tx_ack  in  1  ack from `ip_tx`
- ip_send_type  out  8  protocol of the granted source
- ip_send_data_length  out  16  length of the granted source
- upper_layer_data  out  8  muxed payload byte
- upper_tx_ready  out  1  muxed payload ready
- upper_data_req  in  1  payload request from `ip_tx`
- ip_tx_end  in  1  end-of-frame pulse from `ip_tx`
- busy  out  1  high while a grant is held

Behaviour:
- Reset: state=IDLE, rr_ptr=0 (ICMP has priority), grant=0. All outputs 0, including ip_send_type and ip_send_data_length.
- States: IDLE, REQ, XFER, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - Both req high: grant the port selected by rr_ptr. One req high: grant that port.
  - On grant (next edge): latch grant; drive ip_send_type and ip_send_data_length from the granted port (registered, held stable until return to IDLE); set ip_tx_req=1, busy=1; go to REQ.
  - Latency: req high at edge n means ip_tx_req is high after edge n+1.
- REQ:
  - ip_tx_req held high until ip_tx_ack is sampled high.
  - Then: ip_tx_req=0, pulse <grant>_ack for 1 cycle, go to XFER.
- XFER:
  - upper_layer_data, upper_tx_ready and <grant>_data_req are combinational from the granted port and upper_data_req.
  - Non-granted port: data_req=0. Outside XFER, the muxed outputs are 0.
  - ip_tx_end sampled high: go to DONE.
- DONE:
  - 1 cycle: pulse <grant>_done, rr_ptr = ~grant, busy=0, go to IDLE.
  - Guarantees a 1-cycle gap between frames.
- Watchdog:
  - 20-bit counter, cleared in IDLE and DONE, increments in REQ and XFER.
  - At WDOG_MAX (this covers the case where `ip_tx` silently times out to IDLE): pulse <grant>_err, rr_ptr = ~grant, ip_tx_req=0, busy=0, go directly to IDLE. No done pulse is issued.
- Simultaneous events:
  - ip_tx_end and watchdog expiry in the same cycle: ip_tx_end wins (DONE, no err).
  - ip_tx_ack and watchdog expiry in the same cycle: ack wins.
- Requester drops req after grant: ignored; the frame completes normally.
- ip_tx_end or ip_tx_ack outside its expected state: ignored.
- Reset mid-operation: all state and outputs return to reset values on the next edge; no done or err pulse.

Test Plan:
- ICMP only: icmp_req=1, icmp_length=16'd60 → ip_tx_req rises 1 cycle later; ip_send_type=8'd1, ip_send_data_length=60; ack pulse one cycle after ip_tx_ack; icmp_done one cycle after ip_tx_end; udp_* outputs stay 0.
- Simultaneous icmp_req and udp_req from reset → ICMP served first, then UDP (ip_send_type=8'd17). Third simultaneous request → ICMP again (round-robin alternates).
- XFER data mux: with UDP granted, upper_data_req pulses → udp_data_req follows it combinationally and icmp_data_req stays 0; udp_data=8'hA5 appears on upper_layer_data in the same cycle; upper_tx_ready tracks udp_tx_ready.
- Watchdog: grant ICMP and never return ip_tx_ack → icmp_err pulses at WDOG_MAX cycles, state returns to IDLE, next grant goes to UDP; with WDOG_MAX overridden to 100, the abort occurs after exactly 100 REQ cycles.
- Collision: ip_tx_end asserted in the watchdog-expiry cycle → done pulses, err does not.
- Reset mid-XFER: rstn=0 for 1 cycle → all outputs 0 next cycle, no done or err pulse, ICMP has priority again.
